// File: rtl/stream_argmax_classifier_pkg.sv
// Shared constants, FSM state type and saturating-add helper for the argmax
// classifier at the tail of the CNN pipeline.
package stream_argmax_classifier_pkg;

  localparam int VALUE_BITS      = 18;
  localparam int N               = 8;
  localparam int OUTPUT_CHANNELS = 10;
  localparam int MAX_ACC_BITS    = 64;

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} argmax_state_t;

  typedef struct packed {
    logic                           sat;
    logic signed [MAX_ACC_BITS-1:0] sum;
  } sat_sum_t;

  // Adds two values already in range for a 'bits'-wide signed accumulator and
  // clamps the result to that width; 'bits' must be below MAX_ACC_BITS.
  function automatic sat_sum_t sat_add(input logic signed [MAX_ACC_BITS-1:0] a,
                                       input logic signed [MAX_ACC_BITS-1:0] b,
                                       input int                             bits);
    logic signed [MAX_ACC_BITS:0] s;
    logic signed [MAX_ACC_BITS:0] hi;
    logic signed [MAX_ACC_BITS:0] lo;
    sat_sum_t                     r;
    s     = {a[MAX_ACC_BITS-1], a} + {b[MAX_ACC_BITS-1], b};
    hi    = ((MAX_ACC_BITS+1)'(1) <<< (bits - 1)) - (MAX_ACC_BITS+1)'(1);
    lo    = -hi - (MAX_ACC_BITS+1)'(1);
    r.sat = 1'b0;
    r.sum = s[MAX_ACC_BITS-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi[MAX_ACC_BITS-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo[MAX_ACC_BITS-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_argmax_classifier_sat_accumulator.sv
// One channel's saturating sum over an image, with a sticky clamp flag.
module sat_accumulator
  import stream_argmax_classifier_pkg::*;
#(
  parameter int VALUE_BITS = 18,
  parameter int ACC_BITS   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [VALUE_BITS-1:0] din,
  output logic signed [ACC_BITS-1:0]   acc,
  output logic                         sat
);

  sat_sum_t nxt;
  logic     unused_hi;

  // Both operands are sign-extended before the add.
  always_comb nxt = sat_add(MAX_ACC_BITS'(acc), MAX_ACC_BITS'(din), ACC_BITS);
  assign unused_hi = ^nxt.sum[MAX_ACC_BITS-1:ACC_BITS];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      acc <= nxt.sum[ACC_BITS-1:0];
      sat <= sat | nxt.sat;
    end
  end

endmodule

// File: rtl/stream_argmax_classifier.sv
// Per-image channel sums followed by a serial argmax scan; result held until
// the consumer takes it.
module stream_argmax_classifier
  import stream_argmax_classifier_pkg::*;
#(
  parameter  int VALUE_BITS = stream_argmax_classifier_pkg::VALUE_BITS,
  parameter  int CHANNELS   = OUTPUT_CHANNELS,
  parameter  int ACC_BITS   = 32,
  localparam int IDX_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [VALUE_BITS-1:0] in_data [CHANNELS],
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [IDX_BITS-1:0]          out_class,
  output logic signed [ACC_BITS-1:0]   out_score,
  output logic                         out_sat,
  output logic                         out_valid,
  input  logic                         out_ready
);

  argmax_state_t             state, state_nxt;
  logic signed [ACC_BITS-1:0] acc [CHANNELS];
  logic [CHANNELS-1:0]        sat_vec;
  logic [IDX_BITS-1:0]        ptr;
  logic [IDX_BITS-1:0]        bidx;
  logic signed [ACC_BITS-1:0] best;
  logic                       accept;
  logic                       clear;
  logic                       ptr_last;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign clear     = (state == HOLD) && out_ready;
  assign ptr_last  = (ptr == IDX_BITS'(CHANNELS - 1));

  for (genvar g = 0; g < CHANNELS; g++) begin : g_acc
    sat_accumulator #(
      .VALUE_BITS(VALUE_BITS),
      .ACC_BITS  (ACC_BITS)
    ) u_acc (
      .clk  (clk),
      .reset(reset),
      .clear(clear),
      .en   (accept),
      .din  (in_data[g]),
      .acc  (acc[g]),
      .sat  (sat_vec[g])
    );
  end

  // NOTE: every branch falls back to the default assigned first, so no latch
  // can be inferred on state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nxt = SCAN;
      SCAN:    if (ptr_last)          state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACCUM;
      default:                        state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACCUM;
    else        state <= state_nxt;
  end

  // The first scan cycle seeds best from channel 0, since the final beat only
  // lands in the accumulators on the edge that enters SCAN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr  <= '0;
      bidx <= '0;
      best <= '0;
    end else if (state != SCAN) begin
      ptr <= '0;
    end else begin
      if (ptr == '0) begin
        best <= acc[0];
        bidx <= '0;
      end else if (acc[ptr] > best) begin
        best <= acc[ptr];
        bidx <= ptr;
      end
      ptr <= ptr + 1'b1;
    end
  end

  assign out_class = bidx;
  assign out_score = best;
  assign out_sat   = |sat_vec;

endmodule

// File: tb/tb_stream_argmax_classifier.sv
// Randomized and directed images against a per-image sum/argmax reference model.
module tb_stream_argmax_classifier;

  localparam int VB   = 18;
  localparam int CH   = 10;
  localparam int AB   = 20;
  localparam int IB   = $clog2(CH);
  localparam int MAXB = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic signed [VB-1:0] in_data [CH];
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic [IB-1:0]        out_class;
  logic signed [AB-1:0] out_score;
  logic                 out_sat;
  logic                 out_valid;
  logic                 out_ready = 1'b1;

  stream_argmax_classifier #(
    .VALUE_BITS(VB),
    .CHANNELS  (CH),
    .ACC_BITS  (AB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_class(out_class),
    .out_score(out_score),
    .out_sat  (out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic signed [VB-1:0] img [MAXB][CH];
  int                   nb;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_beat(input int b, input int v[CH]);
    for (int c = 0; c < CH; c++) img[b][c] = VB'(v[c]);
  endtask

  // Reference: clamped running sum per channel, then first maximum wins.
  task automatic model(output int ecls, output longint esc, output bit esat);
    longint s[CH];
    longint hi;
    longint lo;
    hi   = (longint'(1) <<< (AB - 1)) - 1;
    lo   = -hi - 1;
    esat = 1'b0;
    for (int c = 0; c < CH; c++) s[c] = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < CH; c++) begin
        s[c] = s[c] + longint'(img[b][c]);
        if (s[c] > hi) begin
          s[c] = hi;
          esat = 1'b1;
        end else if (s[c] < lo) begin
          s[c] = lo;
          esat = 1'b1;
        end
      end
    end
    ecls = 0;
    esc  = s[0];
    for (int c = 1; c < CH; c++) begin
      if (s[c] > esc) begin
        esc  = s[c];
        ecls = c;
      end
    end
  endtask

  // Entered and left #1 after a rising edge; t_last is the edge that took the last beat.
  task automatic send_image(input int gapmax, output int t_last);
    bit accepted;
    t_last = 0;
    for (int b = 0; b < nb; b++) begin
      in_valid = 1'b0;
      if (gapmax > 0) begin
        repeat ($urandom_range(gapmax, 0)) begin
          @(posedge clk);
          #1;
        end
      end
      for (int c = 0; c < CH; c++) in_data[c] = img[b][c];
      in_valid = 1'b1;
      in_last  = (b == nb - 1);
      accepted = 1'b0;
      for (int n = 0; n < 100 && !accepted; n++) begin
        @(negedge clk);
        if (in_ready) begin
          t_last   = cyc + 1;
          accepted = 1'b1;
        end
        @(posedge clk);
        #1;
      end
      if (!accepted) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input int t_acc, input int stall,
                         input int ecls, input longint esc, input bit esat);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check({tag, "_valid_timeout"}, 0, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      return;
    end
    check({tag, "_latency"}, cyc, t_acc + CH);
    check({tag, "_class"}, out_class, ecls);
    check({tag, "_score"}, out_score, esc);
    check({tag, "_sat"}, out_sat, esat);
    check({tag, "_in_ready_hold"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_class"}, out_class, ecls);
      check({tag, "_stall_score"}, out_score, esc);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_image(input string tag, input int stall, input int gapmax,
                           input int ecls, input longint esc, input bit esat);
    int t;
    out_ready = (stall == 0);
    send_image(gapmax, t);
    collect(tag, t, stall, ecls, esc, esat);
  endtask

  task automatic run_random(input string tag, input int stall, input int gapmax);
    int     ecls;
    longint esc;
    bit     esat;
    model(ecls, esc, esat);
    run_image(tag, stall, gapmax, ecls, esc, esat);
  endtask

  task automatic fill_random(input int mode);
    int v;
    int m;
    m = (mode == 0) ? 2000 : 131071;
    nb = $urandom_range(MAXB, 1);
    for (int b = 0; b < nb; b++) begin
      v = $urandom_range(2 * m, 0) - m;
      for (int c = 0; c < CH; c++) begin
        case (mode)
          2:       img[b][c] = VB'(($urandom_range(3, 0) == 0) ? v - 1 : v);
          3:       img[b][c] = VB'(-int'($urandom_range(m, 0)));
          default: img[b][c] = VB'(int'($urandom_range(2 * m, 0)) - m);
        endcase
      end
    end
  endtask

  initial begin
    int vals[CH];
    int t;
    int ecls;
    longint esc;
    bit esat;
    int n;

    for (int c = 0; c < CH; c++) in_data[c] = '0;

    // Reset held low for three cycles, then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_class", out_class, 0);
    check("rst_out_score", out_score, 0);
    check("rst_out_sat", out_sat, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_class", out_class, 0);
    @(posedge clk);
    #1;

    // Single beat image.
    vals = '{5, -3, 100, 7, 0, 0, 0, 0, 0, -1};
    nb = 1;
    set_beat(0, vals);
    run_image("single", 0, 0, 2, 100, 0);

    // Multi-beat sum: ch7 wins once ch3 is pulled down.
    nb = 4;
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < CH; c++) vals[c] = 0;
      vals[7] = 50;
      vals[3] = (b < 3) ? 60 : -200;
      set_beat(b, vals);
    end
    run_image("multi", 0, 1, 7, 200, 0);

    // All-equal negatives resolve to index 0.
    nb = 1;
    for (int c = 0; c < CH; c++) vals[c] = -4096;
    set_beat(0, vals);
    run_image("tie_neg", 0, 0, 0, -4096, 0);

    // Backpressure with the next image presented during the stall.
    nb = 2;
    for (int c = 0; c < CH; c++) vals[c] = c * 10;
    set_beat(0, vals);
    set_beat(1, vals);
    out_ready = 1'b0;
    send_image(0, t);
    for (int c = 0; c < CH; c++) begin
      vals[c]    = (c == 4) ? 777 : -5;
      in_data[c] = VB'(vals[c]);
    end
    in_valid = 1'b1;
    in_last  = 1'b1;
    collect("bp", t, 20, 9, 180, 0);
    t = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("bp_next", t, 0, 4, 777, 0);

    // Saturation at ACC_BITS=20.
    nb = 8;
    for (int c = 0; c < CH; c++) vals[c] = 0;
    vals[1] = 131071;
    for (int b = 0; b < 8; b++) set_beat(b, vals);
    run_image("sat", 0, 0, 1, 524287, 1);

    // Reset mid-SCAN: no result, accumulators start over.
    nb = 3;
    for (int c = 0; c < CH; c++) vals[c] = 1000 * (c + 1);
    for (int b = 0; b < 3; b++) set_beat(b, vals);
    send_image(0, t);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_scan_valid", out_valid, 0);
    check("rst_scan_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < CH + 2; i++) begin
      @(negedge clk);
      check("rst_scan_stays_idle", out_valid, 0);
    end
    check("rst_scan_score", out_score, 0);
    check("rst_scan_sat", out_sat, 0);
    @(posedge clk);
    #1;
    nb = 1;
    for (int c = 0; c < CH; c++) vals[c] = (c == 6) ? 3 : -2;
    set_beat(0, vals);
    run_image("after_rst_scan", 0, 0, 6, 3, 0);

    // Reset during HOLD drops out_valid without waiting for an edge.
    nb = 1;
    for (int c = 0; c < CH; c++) vals[c] = 9 - c;
    set_beat(0, vals);
    out_ready = 1'b0;
    send_image(0, t);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("rst_hold_reached", out_valid, 1);
    reset = 1'b0;
    #1;
    check("rst_hold_async_drop", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Randomized images across value ranges, gaps and stalls.
    for (int k = 0; k < 40; k++) begin
      fill_random(k % 4);
      run_random($sformatf("rand%0d", k), $urandom_range(3, 0), 2);
    end

    // Saturating random images mixed in.
    for (int k = 0; k < 6; k++) begin
      fill_random(1);
      nb = MAXB;
      for (int b = 0; b < nb; b++) img[b][k] = VB'(-131072 + k);
      model(ecls, esc, esat);
      run_image($sformatf("rsat%0d", k), 0, 0, ecls, esc, esat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
